// File: rtl/ltpi_nl_gpio_scheduler.sv
// ltpi_nl_gpio_scheduler
// Carries the Normal-Latency GPIO vector across LTPI frames, one CHUNK_W
// slice per frame.
//   TX: on each frame_req while the link is up, emits the next indexed chunk
//       one cycle later (tx_valid/tx_idx/tx_data). The whole input vector is
//       snapshotted at the start of every rotation, so one rotation carries
//       one coherent image.
//   RX: accepted indexed chunks (valid, CRC ok, index in range) are written
//       into nl_gpio_out. sync_done reports that every chunk has landed at
//       least once since the link came up. idx_err_cnt counts out-of-range
//       indices and saturates at 255.
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   link_aligned                link operational; gates TX and RX
//   nl_gpio_in                  local GPIO vector to send
//   frame_req                   TX framer asks for the next chunk
//   tx_valid, tx_idx, tx_data   outgoing chunk (one-cycle pulse)
//   rx_frame_valid, rx_crc_ok   received frame strobe and CRC status
//   rx_idx, rx_data             received chunk index and payload
//   nl_gpio_out                 remote GPIO image
//   sync_done                   full rotation received since link-up
//   idx_err_cnt                 saturating out-of-range index count
module ltpi_nl_gpio_scheduler #(
  parameter int NUM_NL_GPIO = 1024,
  parameter int CHUNK_W     = 16,
  parameter int NUM_CHUNKS  = NUM_NL_GPIO / CHUNK_W,
  parameter int IDX_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   link_aligned,
  input  logic [NUM_NL_GPIO-1:0] nl_gpio_in,
  input  logic                   frame_req,
  output logic                   tx_valid,
  output logic [IDX_W-1:0]       tx_idx,
  output logic [CHUNK_W-1:0]     tx_data,
  input  logic                   rx_frame_valid,
  input  logic                   rx_crc_ok,
  input  logic [IDX_W-1:0]       rx_idx,
  input  logic [CHUNK_W-1:0]     rx_data,
  output logic [NUM_NL_GPIO-1:0] nl_gpio_out,
  output logic                   sync_done,
  output logic [7:0]             idx_err_cnt
);

  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);
  // One extra bit so the range check also works when NUM_CHUNKS == 2^IDX_W.
  localparam logic [IDX_W:0] NUM_CHUNKS_X = (IDX_W + 1)'(NUM_CHUNKS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                              state_r;
  state_e                              state_nxt_s;
  logic                                tx_fire_s;
  logic [CNT_W-1:0]                    tx_cnt_r;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]  snap_r;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]  gpio_in_s;
  logic [CHUNK_W-1:0]                  tx_chunk_s;
  logic                                tx_valid_r;
  logic [IDX_W-1:0]                    tx_idx_r;
  logic [CHUNK_W-1:0]                  tx_data_r;

  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]  rx_img_r;
  logic [NUM_CHUNKS-1:0]               rx_bitmap_r;
  logic                                sync_done_r;
  logic [7:0]                          idx_err_cnt_r;
  logic                                rx_in_range_s;
  logic                                rx_accept_s;
  logic                                rx_bad_idx_s;
  logic [CNT_W-1:0]                    rx_slot_s;

  assign gpio_in_s = nl_gpio_in;

  // TX FSM next state; a request is only serviced in RUN with the link still up.
  always_comb begin
    state_nxt_s = state_r;
    tx_fire_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (link_aligned) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!link_aligned) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
          tx_fire_s   = frame_req;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // TX FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Chunk 0 comes straight from the live inputs, which are being captured
  // into the snapshot on that same edge.
  always_comb begin
    if (tx_cnt_r == '0) begin
      tx_chunk_s = gpio_in_s[0];
    end else begin
      tx_chunk_s = snap_r[tx_cnt_r];
    end
  end

  // TX datapath: rotation counter, snapshot and registered chunk outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt_r   <= '0;
      snap_r     <= '0;
      tx_valid_r <= 1'b0;
      tx_idx_r   <= '0;
      tx_data_r  <= '0;
    end else begin
      tx_valid_r <= 1'b0;
      if (!link_aligned) begin
        tx_cnt_r <= '0;
      end else if (tx_fire_s) begin
        tx_valid_r <= 1'b1;
        tx_idx_r   <= IDX_W'(tx_cnt_r);
        tx_data_r  <= tx_chunk_s;
        if (tx_cnt_r == '0) begin
          snap_r <= gpio_in_s;
        end
        if (tx_cnt_r == LAST_CNT) begin
          tx_cnt_r <= '0;
        end else begin
          tx_cnt_r <= tx_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign rx_in_range_s = ({1'b0, rx_idx} < NUM_CHUNKS_X);
  assign rx_accept_s   = link_aligned & rx_frame_valid & rx_crc_ok & rx_in_range_s;
  assign rx_bad_idx_s  = link_aligned & rx_frame_valid & rx_crc_ok & ~rx_in_range_s;
  assign rx_slot_s     = rx_idx[CNT_W-1:0];

  // RX image, arrival bitmap, sync flag and index-error counter. The error
  // counter survives link drops; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_img_r      <= '0;
      rx_bitmap_r   <= '0;
      sync_done_r   <= 1'b0;
      idx_err_cnt_r <= 8'd0;
    end else if (!link_aligned) begin
      rx_img_r    <= '0;
      rx_bitmap_r <= '0;
      sync_done_r <= 1'b0;
    end else begin
      if (rx_accept_s) begin
        rx_img_r[rx_slot_s]    <= rx_data;
        rx_bitmap_r[rx_slot_s] <= 1'b1;
      end
      // Registered from the bitmap, so it rises one cycle after it fills.
      sync_done_r <= &rx_bitmap_r;
      if (rx_bad_idx_s && (idx_err_cnt_r != 8'hFF)) begin
        idx_err_cnt_r <= idx_err_cnt_r + 8'd1;
      end
    end
  end

  assign tx_valid    = tx_valid_r;
  assign tx_idx      = tx_idx_r;
  assign tx_data     = tx_data_r;
  assign nl_gpio_out = rx_img_r;
  assign sync_done   = sync_done_r;
  assign idx_err_cnt = idx_err_cnt_r;

endmodule

// File: tb/tb_ltpi_nl_gpio_scheduler.sv
module tb_ltpi_nl_gpio_scheduler;

  logic          clk = 1'b0;
  logic          reset;
  logic          link_aligned;
  logic [1023:0] nl_gpio_in;
  logic          frame_req;
  logic          tx_valid;
  logic [7:0]    tx_idx;
  logic [15:0]   tx_data;
  logic          rx_frame_valid;
  logic          rx_crc_ok;
  logic [7:0]    rx_idx;
  logic [15:0]   rx_data;
  logic [1023:0] nl_gpio_out;
  logic          sync_done;
  logic [7:0]    idx_err_cnt;

  int errors = 0;
  int checks = 0;
  logic [1023:0] exp_out;
  logic [15:0]   exp_d;

  ltpi_nl_gpio_scheduler dut (
    .clk(clk), .reset(reset), .link_aligned(link_aligned),
    .nl_gpio_in(nl_gpio_in), .frame_req(frame_req),
    .tx_valid(tx_valid), .tx_idx(tx_idx), .tx_data(tx_data),
    .rx_frame_valid(rx_frame_valid), .rx_crc_ok(rx_crc_ok),
    .rx_idx(rx_idx), .rx_data(rx_data),
    .nl_gpio_out(nl_gpio_out), .sync_done(sync_done), .idx_err_cnt(idx_err_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_send(input logic [7:0] idx, input logic [15:0] data, input logic crc);
    rx_frame_valid = 1'b1; rx_crc_ok = crc; rx_idx = idx; rx_data = data;
    tick();
    rx_frame_valid = 1'b0; rx_crc_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; link_aligned = 1'b0; frame_req = 1'b0;
    rx_frame_valid = 1'b0; rx_crc_ok = 1'b0; rx_idx = 8'd0; rx_data = 16'd0;
    nl_gpio_in = '0;
    tick(); tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_idx !== 8'd0) begin errors++; $display("FAIL reset_tx_idx: got %0d want 0", tx_idx); end
    checks++; if (tx_data !== 16'd0) begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
    checks++; if (nl_gpio_out !== 1024'd0) begin errors++; $display("FAIL reset_nl_gpio_out: got %h want 0", nl_gpio_out); end
    checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL reset_sync_done: got %b want 0", sync_done); end
    checks++; if (idx_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_idx_err_cnt: got %0d want 0", idx_err_cnt); end
    reset = 1'b0;
    // Link down: requests are ignored.
    frame_req = 1'b1; tick(); frame_req = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL idle_req_ignored: got %b want 0", tx_valid); end
  endtask

  task automatic test_rotation();
    nl_gpio_in = {64{16'hA5A5}};
    link_aligned = 1'b1;
    tick();
    for (int k = 0; k < 64; k++) begin
      frame_req = 1'b1; tick(); frame_req = 1'b0;
      checks++; if (tx_valid !== 1'b1 || tx_idx !== 8'(k) || tx_data !== 16'hA5A5) begin
        errors++; $display("FAIL rotation_k%0d: got v=%b idx=%0d d=%h want v=1 idx=%0d d=a5a5", k, tx_valid, tx_idx, tx_data, k);
      end
      if (k % 2 == 1) begin
        tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rotation_pulse_k%0d: got %b want 0", k, tx_valid); end
      end
    end
    frame_req = 1'b1; tick(); frame_req = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_idx !== 8'd0) begin
      errors++; $display("FAIL rotation_wrap: got v=%b idx=%0d want v=1 idx=0", tx_valid, tx_idx);
    end
  endtask

  task automatic test_coherency();
    // Request 0 of this rotation already happened; chunk 5 changes now.
    nl_gpio_in[5*16 +: 16] = 16'h1234;
    for (int k = 1; k < 64; k++) begin
      frame_req = 1'b1; tick(); frame_req = 1'b0;
      checks++; if (tx_idx !== 8'(k) || tx_data !== 16'hA5A5) begin
        errors++; $display("FAIL coherency_old_k%0d: got idx=%0d d=%h want idx=%0d d=a5a5", k, tx_idx, tx_data, k);
      end
    end
    nl_gpio_in[15:0] = 16'hBEEF;
    for (int k = 0; k < 6; k++) begin
      exp_d = (k == 0) ? 16'hBEEF : ((k == 5) ? 16'h1234 : 16'hA5A5);
      frame_req = 1'b1; tick(); frame_req = 1'b0;
      checks++; if (tx_valid !== 1'b1 || tx_idx !== 8'(k) || tx_data !== exp_d) begin
        errors++; $display("FAIL coherency_new_k%0d: got v=%b idx=%0d d=%h want idx=%0d d=%h", k, tx_valid, tx_idx, tx_data, k, exp_d);
      end
    end
  endtask

  task automatic test_rx_fill();
    exp_out = '0;
    for (int k = 0; k < 64; k++) begin
      rx_frame_valid = 1'b1; rx_crc_ok = 1'b1; rx_idx = 8'(k); rx_data = 16'(k);
      // Simultaneous TX request (counter is 6 here) must be serviced too.
      if (k == 10) frame_req = 1'b1;
      tick();
      frame_req = 1'b0; rx_frame_valid = 1'b0; rx_crc_ok = 1'b0;
      exp_out[k*16 +: 16] = 16'(k);
      if (k == 10) begin
        checks++; if (tx_valid !== 1'b1 || tx_idx !== 8'd6 || tx_data !== 16'hA5A5) begin
          errors++; $display("FAIL back_to_back_tx_rx: got v=%b idx=%0d d=%h want v=1 idx=6 d=a5a5", tx_valid, tx_idx, tx_data);
        end
      end
      if (k == 0 || k == 62 || k == 63) begin
        checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL rx_sync_early_k%0d: got %b want 0", k, sync_done); end
      end
    end
    checks++; if (nl_gpio_out !== exp_out) begin errors++; $display("FAIL rx_fill_image: got %h want %h", nl_gpio_out, exp_out); end
    tick();
    checks++; if (sync_done !== 1'b1) begin errors++; $display("FAIL rx_sync_rise: got %b want 1", sync_done); end
  endtask

  task automatic test_errors();
    rx_send(8'd3, 16'hFFFF, 1'b0);
    rx_send(8'd64, 16'hFFFF, 1'b0);
    checks++; if (idx_err_cnt !== 8'd0) begin errors++; $display("FAIL badcrc_cnt: got %0d want 0", idx_err_cnt); end
    checks++; if (nl_gpio_out[3*16 +: 16] !== 16'd3) begin errors++; $display("FAIL badcrc_chunk3: got %h want 0003", nl_gpio_out[3*16 +: 16]); end
    for (int i = 0; i < 300; i++) begin
      rx_send(8'd64, 16'hDEAD, 1'b1);
      if (i == 0 || i == 254) begin
        checks++; if (idx_err_cnt !== 8'(i + 1)) begin errors++; $display("FAIL idx_err_step_%0d: got %0d want %0d", i, idx_err_cnt, i + 1); end
      end
    end
    checks++; if (idx_err_cnt !== 8'd255) begin errors++; $display("FAIL idx_err_sat: got %0d want 255", idx_err_cnt); end
    checks++; if (nl_gpio_out !== exp_out) begin errors++; $display("FAIL idx_err_image: got %h want %h", nl_gpio_out, exp_out); end
    checks++; if (sync_done !== 1'b1) begin errors++; $display("FAIL idx_err_sync: got %b want 1", sync_done); end
  endtask

  task automatic test_link_drop();
    // Counter is 7; ten more requests bring it to 17.
    for (int k = 7; k < 17; k++) begin
      frame_req = 1'b1; tick(); frame_req = 1'b0;
    end
    checks++; if (tx_idx !== 8'd16) begin errors++; $display("FAIL drop_pre_idx: got %0d want 16", tx_idx); end
    frame_req = 1'b1; link_aligned = 1'b0;
    rx_frame_valid = 1'b1; rx_crc_ok = 1'b1; rx_idx = 8'd2; rx_data = 16'h7777;
    tick();
    rx_frame_valid = 1'b0; rx_crc_ok = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drop_tx_valid: got %b want 0", tx_valid); end
    checks++; if (nl_gpio_out !== 1024'd0) begin errors++; $display("FAIL drop_image: got %h want 0", nl_gpio_out); end
    checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL drop_sync: got %b want 0", sync_done); end
    checks++; if (idx_err_cnt !== 8'd255) begin errors++; $display("FAIL drop_err_kept: got %0d want 255", idx_err_cnt); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drop_idle_req: got %b want 0", tx_valid); end
    frame_req = 1'b0; link_aligned = 1'b1;
    tick();
    frame_req = 1'b1; tick(); frame_req = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_idx !== 8'd0 || tx_data !== 16'hBEEF) begin
      errors++; $display("FAIL relink_first: got v=%b idx=%0d d=%h want v=1 idx=0 d=beef", tx_valid, tx_idx, tx_data);
    end
    checks++; if (nl_gpio_out !== 1024'd0) begin errors++; $display("FAIL relink_image: got %h want 0", nl_gpio_out); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 7; i++) rx_send(8'd200, 16'h0000, 1'b1);
    for (int k = 0; k < 64; k++) rx_send(8'(k), ~16'(k), 1'b1);
    frame_req = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    frame_req = 1'b0;
    checks++; if (tx_idx !== 8'd39 || idx_err_cnt !== 8'd7 || sync_done !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: got idx=%0d err=%0d sync=%b want idx=39 err=7 sync=1", tx_idx, idx_err_cnt, sync_done);
    end
    reset = 1'b1; frame_req = 1'b1;
    rx_frame_valid = 1'b1; rx_crc_ok = 1'b1; rx_idx = 8'd1; rx_data = 16'h5555;
    tick();
    rx_frame_valid = 1'b0; rx_crc_ok = 1'b0; frame_req = 1'b0;
    checks++; if (tx_valid !== 1'b0 || tx_idx !== 8'd0 || tx_data !== 16'd0) begin
      errors++; $display("FAIL reset_mid_tx: got v=%b idx=%0d d=%h want all 0", tx_valid, tx_idx, tx_data);
    end
    checks++; if (nl_gpio_out !== 1024'd0 || sync_done !== 1'b0 || idx_err_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_mid_rx: got sync=%b err=%0d img=%h want 0", sync_done, idx_err_cnt, nl_gpio_out);
    end
    reset = 1'b0;
    tick();
    frame_req = 1'b1; tick(); frame_req = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_idx !== 8'd0) begin
      errors++; $display("FAIL reset_mid_restart: got v=%b idx=%0d want v=1 idx=0", tx_valid, tx_idx);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_coherency();
    test_rx_fill();
    test_errors();
    test_link_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ltpi_nl_gpio_scheduler.md
Name: ltpi_nl_gpio_scheduler

Overview:
- Sequences Normal-Latency (NL) GPIO tunneling across LTPI frames.
- TX side: slices a wide NL GPIO vector into fixed-width chunks and supplies one indexed chunk per outgoing frame, round-robin.
- RX side: writes received indexed chunks back into the output vector and reports when a full rotation has landed.
- Sits between the GPIO pin block and the LTPI frame TX/RX engines inside the LTPI top.

Parameters:
- NUM_NL_GPIO, 1024: total NL GPIO bits; must be a multiple of CHUNK_W.
- CHUNK_W, 16: NL GPIO bits carried per frame.
- NUM_CHUNKS, NUM_NL_GPIO/CHUNK_W (64): derived chunk count.
- IDX_W, 8: width of the frame index field; must satisfy 2^IDX_W >= NUM_CHUNKS.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- link_aligned  in  1  LTPI link in operational state; gates all scheduling.
- nl_gpio_in  in  NUM_NL_GPIO  local NL GPIO inputs to tunnel.
- frame_req  in  1  one-cycle pulse: TX framer needs the NL payload for its next frame.
- tx_valid  out  1  one-cycle pulse: tx_idx/tx_data valid.
- tx_idx  out  IDX_W  chunk index being sent.
- tx_data  out  CHUNK_W  chunk payload.
- rx_frame_valid  in  1  one-cycle pulse: decoded frame fields valid.
- rx_crc_ok  in  1  CRC of the current received frame passed; qualified by rx_frame_valid.
- rx_idx  in  IDX_W  received chunk index.
- rx_data  in  CHUNK_W  received chunk payload.
- nl_gpio_out  out  NUM_NL_GPIO  remote NL GPIO values.
- sync_done  out  1  every chunk received at least once since link came up.
- idx_err_cnt  out  8  saturating count of out-of-range rx_idx frames.

Behaviour:
- Reset values: tx_valid 0, tx_idx 0, tx_data 0, nl_gpio_out 0, sync_done 0, idx_err_cnt 0.
- Internal reset state: tx counter 0, snapshot 0, rx bitmap 0, FSM = IDLE.

TX FSM (two states):
- IDLE: frame_req is ignored and tx_valid stays 0. Go to RUN on the cycle link_aligned = 1.
- RUN: on frame_req, at the next edge:
  - tx_valid = 1, tx_idx = counter, tx_data = snapshot chunk [counter].
  - counter advances by 1; after NUM_CHUNKS-1 it wraps to 0.
  - Latency is exactly 1 cycle from frame_req to tx_valid.
- Snapshot/coherency: when frame_req arrives with counter = 0, all of nl_gpio_in is captured into the snapshot in the same cycle. Chunk 0 is taken from the fresh sample. Each rotation therefore carries one coherent image.
- Link drop: link_aligned = 0 in RUN forces IDLE on the next edge.
  - Counter resets to 0 and tx_valid is 0.
  - A frame_req coincident with the link drop is dropped.
- frame_req asserted on consecutive cycles is legal: one chunk per request, back to back.

RX path (active whenever link_aligned = 1):
- Accepted frame: rx_frame_valid & rx_crc_ok & rx_idx < NUM_CHUNKS.
  - At the next edge, nl_gpio_out[rx_idx*CHUNK_W +: CHUNK_W] = rx_data and rx bitmap[rx_idx] is set.
- rx_frame_valid & rx_crc_ok & rx_idx >= NUM_CHUNKS: frame dropped; idx_err_cnt increments and saturates at 255.
- rx_frame_valid & !rx_crc_ok: frame dropped with no counter change; bad-CRC accounting is owned by the frame RX block.
- sync_done = 1 one cycle after the bitmap becomes all ones. It stays 1 until link drop or reset.
- Link drop (link_aligned = 0): at the next edge, nl_gpio_out returns to 0, the bitmap clears and sync_done = 0. idx_err_cnt is kept and is cleared only by reset.
- RX frames arriving while link_aligned = 0 are ignored.
- TX and RX are independent: simultaneous frame_req and rx_frame_valid are both serviced in the same cycle.
- Reset mid-rotation: all state returns to reset values at the next edge, with no partial output.

Test Plan:
- Rotation: reset, link_aligned = 1, nl_gpio_in = {64{16'hA5A5}}, then 64 frame_req pulses. Required: tx_idx 0..63 each exactly 1 cycle after its request, tx_data = 16'hA5A5. The 65th request gives tx_idx = 0.
- Coherency: after request 0, change nl_gpio_in chunk 5 to 16'h1234. Required: that rotation sends the old chunk 5 value; the next rotation sends 16'h1234.
- RX fill: send chunks 0..63 with rx_data = index and rx_crc_ok = 1. Required: nl_gpio_out[16*k +: 16] = k, and sync_done rises 1 cycle after chunk 63, not earlier.
- Errors: rx_idx = 64 with CRC ok, 300 times. Required: idx_err_cnt = 255 and nl_gpio_out unchanged. A bad-CRC frame with rx_idx = 3 leaves chunk 3 and the counter unchanged.
- Link drop: drop link_aligned mid-rotation at counter = 17 while frame_req is high. Required: no tx_valid; nl_gpio_out = 0 and sync_done = 0 next cycle. After relink, the first tx_idx = 0.
- Reset: assert reset with a full bitmap, counter = 40 and idx_err_cnt = 7. Required: all outputs at reset values next cycle.
